// File: rtl/pause_pkg.sv
// pause_pkg: shared option bits, pause-cause positions and width helpers for the pause controller.
package pause_pkg;
  localparam int OPT_OSD_PAUSE = 0;
  localparam int OPT_DIM_EN = 1;
  typedef int unsigned src_pos_t;
  localparam src_pos_t SRC_REQ = 0;
  typedef enum logic {RUN, UPAUSE} upause_t;
  function automatic src_pos_t src_user(int n_req);
    return src_pos_t'(n_req);
  endfunction
  function automatic src_pos_t src_osd(int n_req);
    return src_pos_t'(n_req + 1);
  endfunction
  function automatic int clog2_min1(int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/sec_tick.sv
// sec_tick: free-running prescaler emitting a one-cycle tick every TICK_CYCLES clocks while clr is low.
module sec_tick import pause_pkg::*; #(
  parameter int TICK_CYCLES = 30000000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam int CW = clog2_min1(TICK_CYCLES);
  logic [CW-1:0] cnt;
  assign tick = ~clr & (cnt == CW'(TICK_CYCLES - 1));
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= (clr | tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/pause_ctrl_gen.sv
// pause_ctrl_gen: merges user/OSD/external pause causes into a registered CPU halt and fades video while user-paused.
module pause_ctrl_gen import pause_pkg::*; #(
  parameter int RW = 4,
  parameter int GW = 4,
  parameter int BW = 4,
  parameter int N_REQ = 1,
  parameter int TICK_CYCLES = 30000000,
  parameter int DIM_SECS = 10,
  parameter int DIM_MAX = 1
) (
  input  logic                         clk_sys,
  input  logic                         reset,
  input  logic                         user_button,
  input  logic [N_REQ-1:0]             pause_request,
  input  logic                         osd_open,
  input  logic [1:0]                   options,
  input  logic [RW+GW+BW-1:0]          rgb_in,
  output logic [RW+GW+BW-1:0]          rgb_out,
  output logic                         pause_cpu,
  output logic                         dim_video,
  output logic [$clog2(DIM_MAX+1)-1:0] dim_level,
  output logic [N_REQ+1:0]             pause_src
);
  localparam int CW = RW + GW + BW;
  localparam int DW = $clog2(DIM_MAX + 1);
  localparam int SW = clog2_min1(DIM_SECS + 1);
  localparam src_pos_t SU = src_user(N_REQ);
  localparam src_pos_t SO = src_osd(N_REQ);
  upause_t st, st_nxt;
  logic btn_q, btn_edge, active, tick;
  logic [SW-1:0] sec_cnt, sec_nxt;
  logic [DW-1:0] dim_nxt;
  logic [N_REQ+1:0] cause;
  logic [CW-1:0] rgb_dim;
  assign btn_edge = user_button & ~btn_q;
  assign active = (st == UPAUSE) & options[OPT_DIM_EN];
  sec_tick #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk_sys(clk_sys),
    .reset(reset),
    .clr(~active),
    .tick(tick)
  );
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) st <= RUN;
    else st <= st_nxt;
  // Cause vector uses the next user state so a toggle reaches pause_cpu one clock after its edge.
  always_comb begin
    st_nxt = btn_edge ? (st == RUN ? UPAUSE : RUN) : st;
    cause = '0;
    cause[SRC_REQ +: N_REQ] = pause_request;
    cause[SU] = st_nxt == UPAUSE;
    cause[SO] = osd_open & options[OPT_OSD_PAUSE];
    sec_nxt = !active ? '0 : (tick && sec_cnt != SW'(DIM_SECS)) ? sec_cnt + 1'b1 : sec_cnt;
    dim_nxt = !active ? '0
            : (tick && sec_nxt == SW'(DIM_SECS) && dim_level != DW'(DIM_MAX)) ? dim_level + 1'b1
            : dim_level;
  end
  // Shift by the next dim level so pixels and dim_level change on the same clock.
  for (genvar c = 0; c < 3; c++) begin : g_ch
    localparam int W = c == 0 ? BW : c == 1 ? GW : RW;
    localparam int L = c == 0 ? 0 : c == 1 ? BW : BW + GW;
    assign rgb_dim[L +: W] = rgb_in[L +: W] >> dim_nxt;
  end
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) begin
      btn_q <= 1'b0;
      sec_cnt <= '0;
      dim_level <= '0;
      dim_video <= 1'b0;
      pause_src <= '0;
      pause_cpu <= 1'b0;
      rgb_out <= '0;
    end else begin
      btn_q <= user_button;
      sec_cnt <= sec_nxt;
      dim_level <= dim_nxt;
      dim_video <= |dim_nxt;
      pause_src <= cause;
      pause_cpu <= |cause;
      rgb_out <= rgb_dim;
    end
endmodule

// File: tb/tb_pause_ctrl_gen.sv
// tb_pause_ctrl_gen: scoreboard bench driving directed and random pause traffic against a cycle-count reference model.
module tb_pause_ctrl_gen;
  localparam int TICK = 10, DSECS = 3, DMAX = 2;
  logic clk_sys = 0, reset = 0, user_button = 0, osd_open = 0;
  logic [1:0] pause_request = 0, options = 0;
  logic [11:0] rgb_in = 0, rgb_out;
  logic pause_cpu, dim_video;
  logic [1:0] dim_level;
  logic [3:0] pause_src;
  typedef struct packed {
    logic [11:0] rgb;
    logic cpu;
    logic dv;
    logic [1:0] dl;
    logic [3:0] src;
  } exp_t;
  exp_t q[$];
  int checks = 0, fails = 0;
  bit m_up = 0, m_btn = 0;
  int m_n = 0;
  pause_ctrl_gen #(.RW(4), .GW(4), .BW(4), .N_REQ(2), .TICK_CYCLES(TICK), .DIM_SECS(DSECS), .DIM_MAX(DMAX)) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .user_button(user_button),
    .pause_request(pause_request),
    .osd_open(osd_open),
    .options(options),
    .rgb_in(rgb_in),
    .rgb_out(rgb_out),
    .pause_cpu(pause_cpu),
    .dim_video(dim_video),
    .dim_level(dim_level),
    .pause_src(pause_src)
  );
  always #5 clk_sys = ~clk_sys;
  task automatic chk(input string n, input int act, input int req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h at %0t", n, act, req, $time);
    end
  endtask
  function automatic logic [11:0] dim_rgb(input logic [11:0] p, input int s);
    return {p[11:8] >> s, p[7:4] >> s, p[3:0] >> s};
  endfunction
  // Model: dim depth follows from how many consecutive clocks the dim timer has been allowed to run.
  task automatic cyc(input bit b, input logic [1:0] r, input bit o, input logic [1:0] op, input logic [11:0] px);
    exp_t e;
    int t, d;
    @(negedge clk_sys);
    reset = 0;
    user_button = b;
    pause_request = r;
    osd_open = o;
    options = op;
    rgb_in = px;
    m_n = (m_up && op[1]) ? m_n + 1 : 0;
    t = m_n / TICK;
    d = (t < DSECS) ? 0 : (t - DSECS + 1 > DMAX) ? DMAX : t - DSECS + 1;
    if (b && !m_btn) m_up = !m_up;
    m_btn = b;
    e.src = {o & op[0], m_up, r};
    e.cpu = |e.src;
    e.dl = 2'(d);
    e.dv = d != 0;
    e.rgb = dim_rgb(px, d);
    q.push_back(e);
  endtask
  always @(posedge clk_sys) begin
    exp_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("rgb_out", rgb_out, e.rgb);
      chk("pause_cpu", pause_cpu, e.cpu);
      chk("dim_video", dim_video, e.dv);
      chk("dim_level", dim_level, e.dl);
      chk("pause_src", pause_src, e.src);
    end
  end
  task automatic reset_check();
    reset = 1;
    m_up = 0;
    m_btn = 0;
    m_n = 0;
    #1;
    chk("rst_rgb", rgb_out, 0);
    chk("rst_cpu", pause_cpu, 0);
    chk("rst_dim", {dim_video, dim_level}, 0);
    chk("rst_src", pause_src, 0);
  endtask
  initial begin
    bit b;
    logic [1:0] r, op;
    bit o;
    #1;
    reset_check();
    repeat (2) cyc(0, 0, 0, 0, 12'hF8C);
    repeat (5) cyc(1, 0, 0, 0, 12'hF8C);
    repeat (3) cyc(0, 0, 0, 0, 12'hF8C);
    repeat (5) cyc(1, 0, 0, 0, 12'hF8C);
    repeat (3) cyc(0, 0, 0, 0, 12'hF8C);
    cyc(1, 0, 0, 2'b10, 12'hF8C);
    repeat (105) cyc(0, 0, 0, 2'b10, 12'hF8C);
    repeat (2) cyc(0, 0, 0, 2'b00, 12'hF8C);
    cyc(1, 0, 0, 0, 12'hF8C);
    cyc(0, 2'b10, 0, 0, 12'h123);
    repeat (2) cyc(1, 2'b10, 0, 0, 12'h456);
    cyc(0, 2'b10, 0, 0, 12'h789);
    repeat (2) cyc(1, 2'b10, 0, 0, 12'hABC);
    cyc(0, 2'b10, 0, 0, 12'hDEF);
    repeat (2) cyc(0, 2'b00, 0, 0, 12'hFFF);
    repeat (2) cyc(0, 0, 1, 2'b00, 12'h0F0);
    repeat (2) cyc(0, 0, 1, 2'b01, 12'h0F0);
    cyc(0, 0, 0, 0, 12'h000);
    b = 0; r = 0; o = 0; op = 2'b10;
    for (int ph = 0; ph < 2; ph++)
      repeat (1500) begin
        if ($urandom_range(0, ph == 0 ? 7 : 59) == 0) b = ~b;
        if ($urandom_range(0, 19) == 0) r = 2'($urandom);
        if ($urandom_range(0, 15) == 0) o = ~o;
        if ($urandom_range(0, 79) == 0) op = 2'($urandom);
        cyc(b, r, o, op, 12'($urandom));
      end
    cyc(0, 0, 0, 2'b11, 12'hF8C);
    if (!m_up) begin
      cyc(1, 0, 0, 2'b11, 12'hF8C);
      cyc(0, 0, 0, 2'b11, 12'hF8C);
    end
    repeat (45) cyc(0, 0, 0, 2'b11, 12'hF8C);
    @(posedge clk_sys);
    #3;
    reset_check();
    repeat (4) cyc(0, 0, 0, 0, 12'h5A5);
    @(posedge clk_sys);
    #3;
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
